// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg -- shared UART definitions.
//
// Holds the frame format constants, the default clock/line-rate constants
// and the transmit FSM state encoding used by the UART blocks.
// ---------------------------------------------------------------------------
package uart_pkg;

  // 8N1 frame format
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;  // start + data + stop

  // Default system clock and line rate
  localparam int DEFAULT_SYS_CLK_FREQ = 12_000_000;
  localparam int DEFAULT_BAUD_RATE    = 9600;

  // Transmit FSM state encoding
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Clock cycles per bit, integer division
  function automatic int clks_per_bit(input int sys_clk_freq, input int baud_rate);
    return sys_clk_freq / baud_rate;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo -- single-clock FIFO with first-word fall-through read.
//
// Parameters:
//   DEPTH  entries, power of two, >= 2
//   WIDTH  bits per entry
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write request and data; ignored while full
//   pop          read request; ignored while empty
//   rdata        head entry, valid whenever empty is low
//   full, empty  occupancy flags
//   level        entries currently stored (0..DEPTH)
//
// A push while full is refused even if a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage array has no reset; only pointers and level define what is
  // valid, so resetting the contents would add logic for no behavioural gain.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule : uart_sync_fifo

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo -- 8N1 UART transmitter fed by a byte FIFO.
//
// Parameters:
//   SYS_CLK_FREQ  system clock in Hz
//   BAUD_RATE     line rate in bit/s
//   FIFO_DEPTH    queue depth in bytes, power of two, >= 2
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/in_byte byte offered; taken when in_ready is high
//   in_ready         queue has room this cycle
//   tx               registered serial line, idle high
//   is_transmitting  high while a frame is on the line
//   fifo_level       bytes queued (not counting the one being sent)
//
// A byte pushed into an empty queue while idle reaches the line as a start
// bit two cycles after the accepting edge. Queued bytes go out back to back.
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ = DEFAULT_SYS_CLK_FREQ,
  parameter int BAUD_RATE    = DEFAULT_BAUD_RATE,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [7:0]                    in_byte,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          is_transmitting,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CLKS_PER_BIT = clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          launch;
  logic          bit_done;
  logic          start_frame;

  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid && in_ready),
    .pop   (start_frame),
    .wdata (in_byte),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign in_ready = !fifo_full;
  assign bit_done = (clk_cnt == LAST_CLK);

  // From IDLE a frame is launched one cycle after the queue is seen
  // non-empty (launch), giving a fixed two-cycle push-to-start latency.
  // At the end of a stop bit the next byte is launched immediately.
  assign start_frame = !fifo_empty &&
                       (((state == TX_IDLE) && launch) ||
                        ((state == TX_STOP) && bit_done));

  // tx and is_transmitting are assigned together with the state transition,
  // so the line changes on the same edge the FSM enters each state.
  // NOTE: all state here updates with non-blocking assignments so every
  // register sees the pre-edge values of the others, regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= TX_IDLE;
      clk_cnt         <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      launch          <= 1'b0;
      tx              <= 1'b1;
      is_transmitting <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (start_frame) begin
            state           <= TX_START;
            shreg           <= fifo_rdata;
            launch          <= 1'b0;
            tx              <= 1'b0;
            is_transmitting <= 1'b1;
          end else begin
            launch          <= !fifo_empty;
            tx              <= 1'b1;
            is_transmitting <= 1'b0;
          end
        end

        TX_START: begin
          if (bit_done) begin
            clk_cnt <= '0;
            state   <= TX_DATA;
            tx      <= shreg[0];
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        TX_DATA: begin
          if (bit_done) begin
            clk_cnt <= '0;
            bit_idx <= bit_idx + 3'd1;  // wraps 7 -> 0 on the way to STOP
            if (bit_idx == 3'd7) begin
              state <= TX_STOP;
              tx    <= 1'b1;
            end else begin
              tx    <= shreg[1];
              shreg <= {1'b0, shreg[7:1]};
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        TX_STOP: begin
          if (bit_done) begin
            clk_cnt <= '0;
            if (start_frame) begin
              state <= TX_START;
              shreg <= fifo_rdata;
              tx    <= 1'b0;
            end else begin
              state           <= TX_IDLE;
              tx              <= 1'b1;
              is_transmitting <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        default: begin
          state           <= TX_IDLE;
          tx              <= 1'b1;
          is_transmitting <= 1'b0;
        end
      endcase
    end
  end

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo -- directed bench for uart_tx_fifo at CLKS_PER_BIT = 4.
//
// Inputs are driven and outputs sampled on the falling clock edge. A small
// line receiver decodes tx into a queue that is compared at the end against
// the bytes the bench expects to have been sent.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       tx;
  logic       is_transmitting;
  logic [3:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_err = 0;

  uart_tx_fifo #(
    .SYS_CLK_FREQ (40),
    .BAUD_RATE    (10),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_byte         (in_byte),
    .in_ready        (in_ready),
    .tx              (tx),
    .is_transmitting (is_transmitting),
    .fifo_level      (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected line level k cycles after the accepting edge of a byte pushed
  // into an idle, empty transmitter: start bit occupies k = 2..5.
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int bit_no;
    if (k < 2 || k >= 2 + 10 * CPB) return 1'b1;
    bit_no = (k - 2) / CPB;
    if (bit_no == 0) return 1'b0;
    if (bit_no == 9) return 1'b1;
    return b[bit_no - 1];
  endfunction

  // Line receiver: rx_cnt is the cycle index inside the frame, 0 being the
  // first low sample; bits are sampled at mid-bit (index 4*i + 2).
  logic       rx_busy = 1'b0;
  int         rx_cnt  = 0;
  logic [7:0] rx_sh   = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_busy <= 1'b0;
    end else if (!rx_busy) begin
      if (!tx) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == 2 && tx) begin
        rx_err  <= rx_err + 1;
        rx_busy <= 1'b0;
      end else if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt - 2) % CPB == 0) begin
        rx_sh <= {tx, rx_sh[7:1]};
      end else if (rx_cnt == 38) begin
        if (!tx) rx_err <= rx_err + 1;
        rx_q.push_back(rx_sh);
        rx_busy <= 1'b0;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (3) @(negedge clk);
    while ((is_transmitting || fifo_level != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  int tx_high;
  int run;
  int idx;
  int guard;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_byte  = '0;

    // Reset state, no clock edge needed
    #12;
    check("rst_tx", tx, 1);
    check("rst_busy", is_transmitting, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", in_ready, 1);

    // Single byte 0x41, accepted on the first edge after reset release
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h41;
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(8'h41);
    tx_high = 0;
    for (int k = 0; k < 50; k++) begin
      check($sformatf("single_tx_k%0d", k), tx, exp_tx(8'h41, k));
      if (is_transmitting) tx_high++;
      if (k == 0) check("single_lvl_k0", fifo_level, 1);
      if (k == 1) check("single_busy_k1", is_transmitting, 0);
      if (k == 2) check("single_lvl_k2", fifo_level, 0);
      if (k == 2) check("single_busy_k2", is_transmitting, 1);
      @(negedge clk);
    end
    check("single_busy_cycles", tx_high, 40);

    // Burst: three bytes on consecutive cycles, frames back to back
    in_valid = 1'b1;
    in_byte  = 8'h55;
    @(negedge clk);
    check("burst_lvl_0", fifo_level, 1);
    in_byte = 8'hAA;
    @(negedge clk);
    check("burst_lvl_1", fifo_level, 2);
    in_byte = 8'h0F;
    @(negedge clk);
    in_valid = 1'b0;
    check("burst_lvl_2", fifo_level, 2);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h0F);
    run = 0;
    while (is_transmitting && run < 200) begin
      if (run == 40) check("burst_lvl_frame2", fifo_level, 1);
      if (run == 80) check("burst_lvl_frame3", fifo_level, 0);
      run++;
      @(negedge clk);
    end
    check("burst_contiguous", run, 120);
    wait_idle(200);

    // Full: ten continuous pushes, tenth dropped; push refused on pop cycle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 9) begin
        check("full_ready", in_ready, 0);
        check("full_lvl", fifo_level, 8);
      end
      in_valid = 1'b1;
      in_byte  = 8'h10 + 8'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("full_lvl_after_drop", fifo_level, 8);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h10 + 8'(i));
    repeat (32) @(negedge clk);
    check("pop_cycle_lvl", fifo_level, 8);
    check("pop_cycle_ready", in_ready, 0);
    in_valid = 1'b1;
    in_byte  = 8'hEE;
    @(negedge clk);
    in_valid = 1'b0;
    check("pop_cycle_lvl_after", fifo_level, 7);
    check("pop_cycle_ready_after", in_ready, 1);
    wait_idle(600);

    // Reset during DATA bit 3 of 0xC3, with 0x99 still queued
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = 8'hC3;
    @(negedge clk);
    in_byte = 8'h99;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (18) @(negedge clk);
    check("midframe_tx_low", tx, 0);
    check("midframe_lvl", fifo_level, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", is_transmitting, 0);
    check("abort_lvl", fifo_level, 0);
    check("abort_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h7A;
    @(negedge clk);
    in_valid = 1'b0;
    check("after_rst_lvl", fifo_level, 1);
    exp_q.push_back(8'h7A);
    wait_idle(200);

    // Loopback of every byte value, pushing whenever there is room
    idx   = 0;
    guard = 0;
    while (idx < 256 && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (in_ready) begin
        in_valid = 1'b1;
        in_byte  = 8'(idx);
        exp_q.push_back(8'(idx));
        idx++;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("loop_all_pushed", idx, 256);
    wait_idle(1000);

    // Received stream against expected stream
    check("rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      if (rx_q[i] !== exp_q[i]) check($sformatf("rx_byte_%0d", i), rx_q[i], exp_q[i]);
    end
    check("rx_byte_stream", 32'(rx_q == exp_q), 32'd1);
    check("rx_err", rx_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_tx_fifo

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter SYS_CLK_FREQ, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, byte entries; power of two, minimum 2.
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  byte offered for transmission.
REQ-007 SHALL have port in_byte  input  8  byte to transmit.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 SHALL have port tx  output  1  serial line, 8N1, idle high.
REQ-010 SHALL have port is_transmitting  output  1  a frame is on the line.
REQ-011 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  bytes currently queued.

Function
REQ-012 SHALL use bit period CLKS_PER_BIT = SYS_CLK_FREQ/BAUD_RATE (integer division), 1250 at defaults.
REQ-013 SHALL accept a byte on the cycle in_valid && in_ready is high; in_ready = (fifo_level != FIFO_DEPTH).
REQ-014 SHALL ignore in_valid while in_ready is low; the byte is dropped and no state changes.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: when fifo_level > 0, pop the head byte into the shift register and go to START on the next edge.
REQ-017 START: drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-018 DATA: drive in_byte bits LSB first, each for CLKS_PER_BIT cycles; a 3-bit index wraps 7->0 on exit to STOP.
REQ-019 STOP: drive tx=1 for CLKS_PER_BIT cycles, then pop again if the FIFO is non-empty, else go to IDLE.
REQ-020 SHALL send back-to-back frames with no idle gap when the FIFO is non-empty at the end of STOP.
REQ-021 SHALL assert is_transmitting in START, DATA and STOP only.
REQ-022 tx SHALL be registered: glitch-free and high in IDLE.
REQ-023 A simultaneous push and pop SHALL leave fifo_level unchanged and store the pushed byte.
REQ-024 A push into an empty FIFO while the FSM is IDLE SHALL put the start bit on the line 2 cycles after the accepting edge.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 fifo_level SHALL never exceed FIFO_DEPTH or underflow.

Reset
REQ-027 rst_n low SHALL immediately force tx=1, is_transmitting=0, fifo_level=0, in_ready=1, FSM=IDLE, and clear the pointers and bit counters.
REQ-028 Reset during a frame SHALL abort that frame; queued bytes are discarded.
REQ-029 Reset release SHALL take effect synchronously; the first byte can be accepted on the first edge after release.

Structure
REQ-030 The FSM state encoding and the default SYS_CLK_FREQ and BAUD_RATE constants SHALL live in the shared package uart_pkg, alongside the existing UART definitions.
REQ-031 The FIFO SHALL be a sub-module, uart_sync_fifo, with parameters DEPTH and WIDTH=8 and ports push, pop, wdata, rdata, full, empty and level.
REQ-032 The bit-period counter and the FSM SHALL remain in uart_tx_fifo.

Verification (SYS_CLK_FREQ=40, BAUD_RATE=10, so CLKS_PER_BIT=4)
REQ-033 Single byte: push 0x41 -> tx sequence 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles, start bit 2 cycles after the push; is_transmitting high for exactly 40 cycles.
REQ-034 Burst: push 0x55, 0xAA, 0x0F on consecutive cycles -> three frames back-to-back with no idle cycle between them; fifo_level goes 1,2,2 then decrements at each frame start.
REQ-035 Full: push 10 bytes continuously with FIFO_DEPTH=8 -> 1 byte popped and 8 queued, in_ready low, the 10th byte dropped; 9 frames transmitted in order.
REQ-036 Simultaneous: push on the exact cycle the FSM pops, with fifo_level=8 -> push refused (in_ready=0 that cycle), level becomes 7.
REQ-037 Reset mid-frame: assert rst_n=0 during DATA bit 3 of 0xC3 -> tx=1 within the same cycle, fifo_level=0; after release, push 0x7A -> one clean 0x7A frame.
REQ-038 Loopback: connect tx to the existing UART receiver and send 0x00..0xFF -> every byte received equal, recv_error never asserted.
